sparse_layer_accumulator: RTL and testbench
===========================================

# sparse_layer_accumulator

Parametrised single-clock successor to the layer-1 controller. It consumes a frame of active-input indices from a show-ahead index queue and fetches one weight row per index from external weight storage. It accumulates signed per-node sums (optionally seeded with per-node biases), then applies saturating ReLU and presents the result through a valid/ready output buffer. A new frame may accumulate while the previous result is still waiting to be accepted.

## Interface
Parameters:
- NODES, 32, number of output nodes (lanes)
- ADDR_WIDTH, 10, index / weight-row address width
- WEIGHT_WIDTH, 8, signed weight width per node
- ACC_WIDTH, 20, signed accumulator width per node
- OUT_WIDTH, 8, unsigned activation width per node
- SHIFT, 0, right arithmetic shift applied before ReLU

Ports:
- clk  in  1  sole clock, rising edge only
- reset  in  1  asynchronous, active-low reset
- inputs_ready  in  1  upstream frame available; frame starts only when asserted
- queue_empty  in  1  index queue empty
- queue_out  in  ADDR_WIDTH  head of index queue (show-ahead)
- dequeue  out  1  pop head this cycle (combinational)
- mem_addr  out  ADDR_WIDTH  weight-row address, equals queue_out when mem_rd_en=1
- mem_rd_en  out  1  weight read strobe
- mem_data  in  NODES*WEIGHT_WIDTH  weight row, valid exactly 1 cycle after mem_rd_en; node i at bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
- bias_we  in  1  bias write strobe
- bias_addr  in  $clog2(NODES)  node selected for bias write
- bias_data  in  WEIGHT_WIDTH  signed bias value
- out_valid  out  1  layer_out holds a finished frame
- out_ready  in  1  downstream accepts layer_out
- layer_out  out  NODES*OUT_WIDTH  activations; node i at bits [i*OUT_WIDTH +: OUT_WIDTH]
- busy  out  1  state is not IDLE

## Operation
- States: IDLE, RUN, DRAIN, ACT, WAIT_OUT.
- IDLE -> RUN when inputs_ready=1 and queue_empty=0. On this edge each accumulator loads its sign-extended bias, or 0 when the bias feature is compiled out.
- RUN: dequeue = mem_rd_en = !queue_empty, and mem_addr = queue_out. A 1-cycle registered read-valid pipe adds sign-extended mem_data lane-wise to the accumulators. RUN -> DRAIN when queue_empty=1.
- DRAIN: one cycle that absorbs the last outstanding read. -> ACT.
- ACT: if out_valid=0, or out_ready=1 in the same cycle, latch the activations into layer_out, set out_valid, and go to IDLE. Otherwise go to WAIT_OUT.
- WAIT_OUT: hold the accumulators. Take the ACT latch action on the first cycle with out_ready=1 or out_valid=0, then go to IDLE.
- Handshake: out_valid clears on the cycle out_valid and out_ready are both 1, unless a new latch occurs that same cycle, in which case out_valid stays 1 with new data. layer_out is stable while out_valid=1 and not accepted.
- Arithmetic: accumulator adds saturate at signed ACC_WIDTH bounds. The activation is a = acc >>> SHIFT. If a<0, output 0. If a > 2^OUT_WIDTH-1, output 2^OUT_WIDTH-1. Otherwise output a[OUT_WIDTH-1:0].
- Queue going empty mid-frame ends the frame; later indices belong to the next frame.

## Timing
- Reset values: dequeue=0, mem_rd_en=0, mem_addr=0, out_valid=0, layer_out=0, busy=0. State is IDLE, accumulators and biases are 0.
- Reset asserted mid-frame aborts the frame immediately. Any in-flight mem_data is discarded.
- Throughput: 1 index per cycle.
- Latency: the last dequeue is followed by DRAIN (+1 cycle) and ACT (+1 cycle). out_valid rises on the edge leaving ACT, 3 edges after the last dequeue edge, when the buffer is free.
- Bias write while busy updates the register but affects only the next frame. A write on the IDLE->RUN edge is not seen by that frame.

## Configuration
- SPARSE_LAYER_BIAS_EN defined: NODES bias registers exist, bias_we/bias_addr/bias_data are functional, and accumulators are seeded from the biases.
- SPARSE_LAYER_BIAS_EN undefined: no bias storage, bias ports are ignored, and accumulators are seeded with 0.

## Test plan
Test configuration: NODES=4, WEIGHT_WIDTH=8, ACC_WIDTH=16, OUT_WIDTH=8, SHIFT=0, bias enabled.
- Basic frame: indices {3,7}, row3 lanes={10,-5,1,0}, row7 lanes={20,2,-3,100}, biases 0 -> layer_out lanes={30,0,0,100}. out_valid rises 3 edges after the second dequeue.
- Bias: bias node0=-40, single index with lane0=30 -> lane0=0. With bias node0=+40 -> lane0=70.
- Saturation: 5 indices, each with lane1=127 -> sum 635, output lane1=255. Also 300 indices with lane2=127 -> accumulator clamps at 32767, output 255.
- Back-pressure: out_ready=0 while a second frame completes -> state is WAIT_OUT, first layer_out is unchanged. Raise out_ready -> the same-cycle handoff keeps out_valid=1 with the second frame's data.
- Reset mid-RUN after 2 of 4 indices -> next edge shows out_valid=0, dequeue=0, busy=0. A following frame yields results with no residue from the aborted frame.
- Compile without SPARSE_LAYER_BIAS_EN: bias writes of 50 have no effect, single index lane0=10 -> output 10.

Source files
------------

// File: rtl/sparse_layer_accumulator_if.sv
// Bundle of the index-queue, weight-memory, bias-write and result-buffer
// signals of sparse_layer_accumulator; slave is the accumulator side.
interface sparse_layer_accumulator_if #(
  parameter int unsigned NODES        = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned OUT_WIDTH    = 8
);
  localparam int unsigned NODE_AW = (NODES > 1) ? $clog2(NODES) : 1;

  logic                          inputs_ready;
  logic                          queue_empty;
  logic [ADDR_WIDTH-1:0]         queue_out;
  logic                          dequeue;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic                          mem_rd_en;
  logic [NODES*WEIGHT_WIDTH-1:0] mem_data;
  logic                          bias_we;
  logic [NODE_AW-1:0]            bias_addr;
  logic [WEIGHT_WIDTH-1:0]       bias_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [NODES*OUT_WIDTH-1:0]    layer_out;
  logic                          busy;

  modport master (
    output inputs_ready, queue_empty, queue_out, mem_data,
           bias_we, bias_addr, bias_data, out_ready,
    input  dequeue, mem_addr, mem_rd_en, out_valid, layer_out, busy
  );

  modport slave (
    input  inputs_ready, queue_empty, queue_out, mem_data,
           bias_we, bias_addr, bias_data, out_ready,
    output dequeue, mem_addr, mem_rd_en, out_valid, layer_out, busy
  );
endinterface

// File: rtl/sparse_layer_accumulator.sv
// Sparse layer accumulator: per-index weight-row accumulation, saturating ReLU,
// valid/ready result buffer. Optional bias seeding via SPARSE_LAYER_BIAS_EN.
module sparse_layer_accumulator #(
  parameter int unsigned NODES        = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned ACC_WIDTH    = 20,
  parameter int unsigned OUT_WIDTH    = 8,
  parameter int unsigned SHIFT        = 0
) (
  input logic                      clk,
  input logic                      reset,
  sparse_layer_accumulator_if.slave bus
);

  localparam int unsigned ACC_EXT = ACC_WIDTH - WEIGHT_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH-1:0]        OUT_MAX = ACC_WIDTH'({OUT_WIDTH{1'b1}});

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, ACT, WAIT_OUT} stateT;

  stateT                        state;
  logic                         rdValid;
  logic                         outValid;
  logic [NODES*OUT_WIDTH-1:0]   layerOut;
  logic signed [ACC_WIDTH-1:0]  acc    [NODES];
  logic signed [ACC_WIDTH-1:0]  sumC   [NODES];
  logic signed [ACC_WIDTH-1:0]  seedC  [NODES];
  logic [NODES*OUT_WIDTH-1:0]   actPackedC;
  logic                         startC;
  logic                         rdEnC;
  logic                         latchC;
  logic [ADDR_WIDTH-1:0]        addrC;

  // Signed add clamped to the accumulator range.
  function automatic logic signed [ACC_WIDTH-1:0] satAdd(
    input logic signed [ACC_WIDTH-1:0]    a,
    input logic signed [WEIGHT_WIDTH-1:0] w
  );
    logic signed [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {{(ACC_EXT+1){w[WEIGHT_WIDTH-1]}}, w};
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
      return s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
    return s[ACC_WIDTH-1:0];
  endfunction

  // Shift, then clamp to [0, 2^OUT_WIDTH-1].
  function automatic logic [OUT_WIDTH-1:0] relu(input logic signed [ACC_WIDTH-1:0] v);
    logic signed [ACC_WIDTH-1:0] a;
    logic [ACC_WIDTH-1:0]        au;
    a  = v >>> SHIFT;
    au = a;
    if (a[ACC_WIDTH-1]) begin
      return '0;
    end
    if (au > OUT_MAX) begin
      return '1;
    end
    return au[OUT_WIDTH-1:0];
  endfunction

`ifdef SPARSE_LAYER_BIAS_EN
  localparam int unsigned NODE_AW = (NODES > 1) ? $clog2(NODES) : 1;

  logic signed [WEIGHT_WIDTH-1:0] biasReg [NODES];

  // Bias writes land at any time; a frame samples them only on its start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NODES; i++) biasReg[i] <= '0;
    end else if (bus.bias_we && (32'(bus.bias_addr) < NODES)) begin
      biasReg[bus.bias_addr] <= bus.bias_data;
    end
  end

  always_comb begin
    for (int i = 0; i < NODES; i++) begin
      seedC[i] = {{ACC_EXT{biasReg[i][WEIGHT_WIDTH-1]}}, biasReg[i]};
    end
  end
`else
  wire unusedBias = ^{bus.bias_we, bus.bias_addr, bus.bias_data};

  always_comb begin
    for (int i = 0; i < NODES; i++) seedC[i] = '0;
  end
`endif

  assign startC = (state == IDLE) && bus.inputs_ready && !bus.queue_empty;
  assign rdEnC  = (state == RUN) && !bus.queue_empty;
  assign addrC  = rdEnC ? bus.queue_out : '0;
  assign latchC = ((state == ACT) || (state == WAIT_OUT)) && (!outValid || bus.out_ready);

  assign bus.dequeue   = rdEnC;
  assign bus.mem_rd_en = rdEnC;
  assign bus.mem_addr  = addrC;
  assign bus.out_valid = outValid;
  assign bus.layer_out = layerOut;
  assign bus.busy      = (state != IDLE);

  // Lane-wise next sums and activations.
  always_comb begin
    actPackedC = '0;
    for (int i = 0; i < NODES; i++) begin
      sumC[i] = satAdd(acc[i], bus.mem_data[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
      actPackedC[i*OUT_WIDTH +: OUT_WIDTH] = relu(acc[i]);
    end
  end

  // Frame sequencing, accumulators and output buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rdValid  <= 1'b0;
      outValid <= 1'b0;
      layerOut <= '0;
      for (int i = 0; i < NODES; i++) acc[i] <= '0;
    end else begin
      rdValid <= rdEnC;

      for (int i = 0; i < NODES; i++) begin
        if (startC) begin
          acc[i] <= seedC[i];
        end else if (rdValid) begin
          acc[i] <= sumC[i];
        end
      end

      // A latch on the accepting edge keeps out_valid high with the new frame.
      if (latchC) begin
        layerOut <= actPackedC;
        outValid <= 1'b1;
      end else if (outValid && bus.out_ready) begin
        outValid <= 1'b0;
      end

      case (state)
        IDLE:     if (startC) state <= RUN;
        RUN:      if (bus.queue_empty) state <= DRAIN;
        DRAIN:    state <= ACT;
        ACT:      state <= latchC ? IDLE : WAIT_OUT;
        WAIT_OUT: if (latchC) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_layer_accumulator.sv
// Directed bench for sparse_layer_accumulator (NODES=4, ACC_WIDTH=16) with an
// index-queue/weight-memory model and an expected-result scoreboard.
module tb_sparse_layer_accumulator;

  localparam int unsigned NODES        = 4;
  localparam int unsigned ADDR_WIDTH   = 10;
  localparam int unsigned WEIGHT_WIDTH = 8;
  localparam int unsigned ACC_WIDTH    = 16;
  localparam int unsigned OUT_WIDTH    = 8;
  localparam int unsigned SHIFT        = 0;

  logic clk;
  logic reset;

  sparse_layer_accumulator_if #(
    .NODES(NODES), .ADDR_WIDTH(ADDR_WIDTH),
    .WEIGHT_WIDTH(WEIGHT_WIDTH), .OUT_WIDTH(OUT_WIDTH)
  ) bus ();

  sparse_layer_accumulator #(
    .NODES(NODES), .ADDR_WIDTH(ADDR_WIDTH), .WEIGHT_WIDTH(WEIGHT_WIDTH),
    .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [31:0] rows [1024];
  int          idxList [1024];
  int          wrPtr = 0;
  int          rdPtr = 0;
  int          cyc = 0;
  int          lastDeqEdge = 0;
  logic        flushReq = 1'b0;
  int          biasModel [4];
  int          vectors = 0;
  int          errs = 0;
  logic [31:0] expQ [$];
  logic [31:0] lastExp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  assign bus.queue_empty = (rdPtr == wrPtr);
  assign bus.queue_out   = ADDR_WIDTH'(idxList[rdPtr]);

  // Show-ahead queue pop and weight memory with one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flushReq) begin
      rdPtr <= wrPtr;
    end else if (bus.dequeue) begin
      rdPtr       <= rdPtr + 1;
      lastDeqEdge <= cyc + 1;
    end
    if (bus.mem_rd_en) bus.mem_data <= rows[bus.mem_addr];
    else               bus.mem_data <= $urandom();
  end

  function automatic logic [31:0] mkRow(input int l0, input int l1, input int l2, input int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  // Reference result for the indices idxList[s..e-1].
  function automatic logic [31:0] model(input int s, input int e);
    logic [31:0] r;
    logic [31:0] row;
    int          a;
    int          w;
    int          o;
    r = '0;
    for (int lane = 0; lane < 4; lane++) begin
      a = biasModel[lane];
      for (int k = s; k < e; k++) begin
        row = rows[idxList[k]];
        w   = int'($signed(row[lane*8 +: 8]));
        a   = a + w;
        if (a > 32767)  a = 32767;
        if (a < -32768) a = -32768;
      end
      o = (a < 0) ? 0 : ((a > 255) ? 255 : a);
      r[lane*8 +: 8] = 8'(o);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pushIdx(input int idx, input int n);
    for (int k = 0; k < n; k++) begin
      idxList[wrPtr] = idx;
      wrPtr++;
    end
  endtask

  task automatic startFrame(input int idx, input int n);
    int s;
    s = wrPtr;
    pushIdx(idx, n);
    expQ.push_back(model(s, wrPtr));
  endtask

  task automatic writeBias(input int node, input int val);
    bus.bias_we   = 1'b1;
    bus.bias_addr = 2'(node);
    bus.bias_data = 8'(val);
    @(negedge clk);
    bus.bias_we   = 1'b0;
`ifdef SPARSE_LAYER_BIAS_EN
    biasModel[node] = val;
`endif
  endtask

  task automatic waitValid(input string tag, input int budget);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, " valid"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic checkOut(input string tag);
    lastExp = expQ.pop_front();
    check(tag, bus.layer_out, lastExp);
  endtask

  task automatic acceptOut(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, " cleared"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int s;
    int n;
    for (int i = 0; i < 1024; i++) rows[i] = '0;
    for (int i = 0; i < 4; i++) biasModel[i] = 0;
    rows[3]  = mkRow(10, -5, 1, 0);
    rows[7]  = mkRow(20, 2, -3, 100);
    rows[5]  = mkRow(30, 0, 0, 0);
    rows[9]  = mkRow(0, 127, 0, 0);
    rows[11] = mkRow(0, 0, 127, 0);
    rows[13] = mkRow(10, 0, 0, 0);

    reset            = 1'b0;
    bus.inputs_ready = 1'b0;
    bus.out_ready    = 1'b0;
    bus.bias_we      = 1'b0;
    bus.bias_addr    = '0;
    bus.bias_data    = '0;
    repeat (3) @(negedge clk);

    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset layer_out", bus.layer_out, 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset dequeue", 32'(bus.dequeue), 32'd0);
    check("reset mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Basic frame {3,7}, held until inputs_ready rises.
    s = wrPtr;
    pushIdx(3, 1);
    pushIdx(7, 1);
    expQ.push_back(model(s, wrPtr));
    repeat (3) @(negedge clk);
    check("gate busy", 32'(bus.busy), 32'd0);
    check("gate dequeue", 32'(bus.dequeue), 32'd0);
    bus.inputs_ready = 1'b1;
    waitValid("basic", 20);
    check("basic latency", 32'(cyc - lastDeqEdge), 32'd3);
    checkOut("basic data");
    acceptOut("basic");

    // Bias seeding, negative then positive.
    writeBias(0, -40);
    startFrame(5, 1);
    waitValid("bias neg", 20);
    checkOut("bias neg data");
    acceptOut("bias neg");
    writeBias(0, 40);
    startFrame(5, 1);
    waitValid("bias pos", 20);
    checkOut("bias pos data");
    acceptOut("bias pos");

    // Output clamp and accumulator clamp.
    startFrame(9, 5);
    waitValid("sat5", 30);
    checkOut("sat5 data");
    acceptOut("sat5");
    startFrame(11, 300);
    waitValid("sat300", 400);
    checkOut("sat300 data");
    acceptOut("sat300");

    // Back-pressure: second frame parks in WAIT_OUT, then same-cycle handoff.
    writeBias(0, 0);
    startFrame(3, 1);
    waitValid("bp first", 20);
    checkOut("bp first data");
    startFrame(7, 1);
    repeat (8) @(negedge clk);
    check("bp wait busy", 32'(bus.busy), 32'd1);
    check("bp wait valid", 32'(bus.out_valid), 32'd1);
    check("bp wait hold", bus.layer_out, lastExp);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp handoff valid", 32'(bus.out_valid), 32'd1);
    check("bp handoff busy", 32'(bus.busy), 32'd0);
    checkOut("bp handoff data");
    acceptOut("bp second");

    // Reset after two of four indices.
    s = wrPtr;
    pushIdx(3, 1);
    pushIdx(7, 1);
    pushIdx(5, 1);
    pushIdx(9, 1);
    n = 0;
    while ((rdPtr - s) < 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort dequeued", 32'(rdPtr - s), 32'd2);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort out_valid", 32'(bus.out_valid), 32'd0);
    check("abort dequeue", 32'(bus.dequeue), 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 4; i++) biasModel[i] = 0;
    @(negedge clk);
    flushReq = 1'b1;
    @(negedge clk);
    flushReq = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    s = wrPtr;
    pushIdx(3, 1);
    pushIdx(7, 1);
    expQ.push_back(model(s, wrPtr));
    waitValid("post abort", 20);
    checkOut("post abort data");
    acceptOut("post abort");

    // Bias of 50 on node0 counts only when biases are compiled in.
    writeBias(0, 50);
    startFrame(13, 1);
    waitValid("bias cfg", 20);
    checkOut("bias cfg data");
    acceptOut("bias cfg");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
